// File: rtl/lsu_ahbl_master.sv
// Core data-side req/gnt/rvalid port to a single AHB-Lite master.
// One bus data phase in flight, plus at most one locally generated error for illegal byte enables.
module lsu_ahbl_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic [ADDR_WIDTH-1:0] ahbl_haddr,
    output logic [2:0]            ahbl_hburst,
    output logic                  ahbl_hmastlock,
    output logic [3:0]            ahbl_hprot,
    output logic [2:0]            ahbl_hsize,
    output logic [1:0]            ahbl_htrans,
    output logic [DATA_WIDTH-1:0] ahbl_hwdata,
    output logic                  ahbl_hwrite,
    input  logic [DATA_WIDTH-1:0] ahbl_hrdata,
    input  logic                  ahbl_hready,
    input  logic                  ahbl_hresp
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    logic                  dph_valid_q, dph_valid_d;
    logic                  dph_we_q, dph_we_d;
    logic                  lerr_pend_q, lerr_pend_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;

    logic       be_legal;
    logic [2:0] be_size;
    logic [1:0] be_offset;
    logic       blk;
    logic       gnt;
    logic       dph_done;
    logic       unused_addr;

    // Address is word aligned; the low bits come from the byte enables instead.
    assign unused_addr = ^data_addr_i[1:0];

    always_comb begin
        be_legal  = 1'b1;
        be_size   = 3'd0;
        be_offset = 2'd0;
        case (data_be_i)
            4'b0001: begin be_size = 3'd0; be_offset = 2'd0; end
            4'b0010: begin be_size = 3'd0; be_offset = 2'd1; end
            4'b0100: begin be_size = 3'd0; be_offset = 2'd2; end
            4'b1000: begin be_size = 3'd0; be_offset = 2'd3; end
            4'b0011: begin be_size = 3'd1; be_offset = 2'd0; end
            4'b1100: begin be_size = 3'd1; be_offset = 2'd2; end
            4'b1111: begin be_size = 3'd2; be_offset = 2'd0; end
            default: be_legal = 1'b0;
        endcase
    end

    // An erroring data phase or a pending local error holds off any new address phase.
    assign blk      = (dph_valid_q && ahbl_hresp) || lerr_pend_q;
    assign gnt      = !rst && data_req_i && ahbl_hready && !blk && (be_legal || !dph_valid_q);
    assign dph_done = dph_valid_q && ahbl_hready;

    assign data_gnt_o     = gnt;
    assign ahbl_haddr     = {data_addr_i[ADDR_WIDTH-1:2], be_offset};
    assign ahbl_hsize     = be_size;
    assign ahbl_hwrite    = data_we_i;
    assign ahbl_htrans    = (!rst && data_req_i && !blk && be_legal) ? TransNonseq : TransIdle;
    assign ahbl_hburst    = 3'b000;
    assign ahbl_hmastlock = 1'b0;
    assign ahbl_hprot     = 4'b0011;
    assign ahbl_hwdata    = hwdata_q;

    // The two response sources are mutually exclusive: a local error is only granted when idle.
    assign data_rvalid_o = dph_done || lerr_pend_q;
    assign data_err_o    = lerr_pend_q || (dph_done && ahbl_hresp);
    assign data_rdata_o  = (dph_done && !dph_we_q) ? ahbl_hrdata : '0;

    always_comb begin
        dph_valid_d = dph_valid_q;
        dph_we_d    = dph_we_q;
        hwdata_d    = hwdata_q;
        lerr_pend_d = gnt && !be_legal;
        if (ahbl_hready) begin
            dph_valid_d = gnt && be_legal;
        end
        if (gnt && be_legal) begin
            dph_we_d = data_we_i;
            hwdata_d = data_wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dph_valid_q <= 1'b0;
            dph_we_q    <= 1'b0;
            lerr_pend_q <= 1'b0;
            hwdata_q    <= '0;
        end else begin
            dph_valid_q <= dph_valid_d;
            dph_we_q    <= dph_we_d;
            lerr_pend_q <= lerr_pend_d;
            hwdata_q    <= hwdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_ahbl_master.sv
// Directed bench for lsu_ahbl_master against a small word-addressed SRAM slave model.
module tb_lsu_ahbl_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'b1111;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] ahbl_haddr;
    logic [2:0]  ahbl_hburst;
    logic        ahbl_hmastlock;
    logic [3:0]  ahbl_hprot;
    logic [2:0]  ahbl_hsize;
    logic [1:0]  ahbl_htrans;
    logic [31:0] ahbl_hwdata;
    logic        ahbl_hwrite;
    logic [31:0] ahbl_hrdata;
    logic        ahbl_hready = 1'b1;
    logic        ahbl_hresp = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_ahbl_master dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .ahbl_haddr     (ahbl_haddr),
        .ahbl_hburst    (ahbl_hburst),
        .ahbl_hmastlock (ahbl_hmastlock),
        .ahbl_hprot     (ahbl_hprot),
        .ahbl_hsize     (ahbl_hsize),
        .ahbl_htrans    (ahbl_htrans),
        .ahbl_hwdata    (ahbl_hwdata),
        .ahbl_hwrite    (ahbl_hwrite),
        .ahbl_hrdata    (ahbl_hrdata),
        .ahbl_hready    (ahbl_hready),
        .ahbl_hresp     (ahbl_hresp)
    );

    // Packed views: {gnt, htrans, haddr, hsize, hwrite} and {rvalid, err, rdata}.
    logic [38:0] aph;
    logic [33:0] rsp;
    assign aph = {data_gnt_o, ahbl_htrans, ahbl_haddr, ahbl_hsize, ahbl_hwrite};
    assign rsp = {data_rvalid_o, data_err_o, data_rdata_o};

    // SRAM slave model: 16 words, byte-lane writes honour hsize/haddr.
    logic [31:0] mem [16];
    logic        sl_dph = 1'b0;
    logic [31:0] sl_addr = 32'h0;
    logic        sl_write = 1'b0;
    logic [2:0]  sl_size = 3'd0;
    logic [3:0]  sl_mask;

    always_comb begin
        sl_mask = 4'b1111;
        case (sl_size)
            3'd0:    sl_mask = 4'b0001 << sl_addr[1:0];
            3'd1:    sl_mask = 4'b0011 << sl_addr[1:0];
            default: sl_mask = 4'b1111;
        endcase
    end

    assign ahbl_hrdata = mem[sl_addr[5:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sl_dph <= 1'b0;
        end else if (ahbl_hready) begin
            if (sl_dph && sl_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (sl_mask[i]) mem[sl_addr[5:2]][8*i +: 8] <= ahbl_hwdata[8*i +: 8];
                end
            end
            sl_dph   <= ahbl_htrans[1];
            sl_addr  <= ahbl_haddr;
            sl_write <= ahbl_hwrite;
            sl_size  <= ahbl_hsize;
        end
    end

    // Drive one cycle's inputs at the falling edge; outputs are then sampled 1 time unit later.
    task automatic cyc(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic hready, input logic hresp);
        @(negedge clk);
        data_req_i   = req;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        ahbl_hready  = hready;
        ahbl_hresp   = hresp;
        #1;
    endtask

    task automatic test_reset;
        data_req_i = 1'b1;
        data_addr_i = 32'h1000;
        #1;
        checks++;
        if ({aph[38:37], rsp, ahbl_hwdata} !== {3'b000, 34'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs got gnt/htrans=%b rsp=%h hwdata=%h", aph[38:36], rsp, ahbl_hwdata);
        end
        checks++;
        if ({ahbl_hburst, ahbl_hmastlock, ahbl_hprot} !== {3'b000, 1'b0, 4'b0011}) begin
            errors++;
            $display("FAIL const_ctrl got %b exp 00000011", {ahbl_hburst, ahbl_hmastlock, ahbl_hprot});
        end
        @(negedge clk);
        data_req_i = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write_word;
        cyc(1'b1, 1'b1, 4'b1111, 32'h1000, 32'hDEADBEEF, 1'b1, 1'b0);
        checks++;
        if (aph !== {1'b1, 2'b10, 32'h1000, 3'd2, 1'b1}) begin
            errors++; $display("FAIL wr_word_aph got %h exp %h", aph, {1'b1, 2'b10, 32'h1000, 3'd2, 1'b1});
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({ahbl_hwdata, rsp, ahbl_htrans} !== {32'hDEADBEEF, 2'b10, 32'h0, 2'b00}) begin
            errors++; $display("FAIL wr_word_dph got hwdata=%h rsp=%h htrans=%b", ahbl_hwdata, rsp, ahbl_htrans);
        end
    endtask

    task automatic test_byte_write;
        cyc(1'b1, 1'b1, 4'b0100, 32'h1004, 32'h00AB0000, 1'b1, 1'b0);
        checks++;
        if (aph !== {1'b1, 2'b10, 32'h1006, 3'd0, 1'b1}) begin
            errors++; $display("FAIL byte_wr_aph got %h exp %h", aph, {1'b1, 2'b10, 32'h1006, 3'd0, 1'b1});
        end
        cyc(1'b1, 1'b0, 4'b1111, 32'h1004, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, ahbl_haddr, data_rvalid_o, data_err_o} !== {1'b1, 32'h1004, 2'b10}) begin
            errors++; $display("FAIL byte_rd_aph got gnt=%b haddr=%h rv/err=%b%b", data_gnt_o, ahbl_haddr, data_rvalid_o, data_err_o);
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_rvalid_o, data_err_o, data_rdata_o[23:16]} !== {2'b10, 8'hAB}) begin
            errors++; $display("FAIL byte_rd_data got rv/err=%b%b lane2=%h exp 10 ab", data_rvalid_o, data_err_o, data_rdata_o[23:16]);
        end
    endtask

    task automatic test_back_to_back;
        cyc(1'b1, 1'b0, 4'b1111, 32'h1000, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, data_rvalid_o} !== 2'b10) begin
            errors++; $display("FAIL b2b_c1 got gnt/rvalid=%b%b exp 10", data_gnt_o, data_rvalid_o);
        end
        cyc(1'b1, 1'b0, 4'b1111, 32'h1008, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, rsp} !== {1'b1, 2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL b2b_c2 got gnt=%b rsp=%h exp gnt=1 rsp=%h", data_gnt_o, rsp, {2'b10, 32'hDEADBEEF});
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, data_rvalid_o, data_err_o} !== 3'b010) begin
            errors++; $display("FAIL b2b_c3 got gnt/rvalid/err=%b exp 010", {data_gnt_o, data_rvalid_o, data_err_o});
        end
    endtask

    task automatic test_stall;
        cyc(1'b1, 1'b1, 4'b1111, 32'h100C, 32'h12345678, 1'b1, 1'b0);
        checks++;
        if (data_gnt_o !== 1'b1) begin
            errors++; $display("FAIL stall_wr_gnt got %b exp 1", data_gnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 4'b1111, 32'h1000, 32'h0, 1'b0, 1'b0);
            checks++;
            if ({data_gnt_o, data_rvalid_o, ahbl_htrans, ahbl_haddr, ahbl_hwdata} !==
                {2'b00, 2'b10, 32'h1000, 32'h12345678}) begin
                errors++; $display("FAIL stall_hold_%0d got gnt/rv=%b%b htrans=%b haddr=%h hwdata=%h", i,
                                   data_gnt_o, data_rvalid_o, ahbl_htrans, ahbl_haddr, ahbl_hwdata);
            end
        end
        cyc(1'b1, 1'b0, 4'b1111, 32'h1000, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, data_rvalid_o, data_err_o} !== 3'b110) begin
            errors++; $display("FAIL stall_release got gnt/rvalid/err=%b exp 110", {data_gnt_o, data_rvalid_o, data_err_o});
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (rsp !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL stall_queued_rd got %h exp %h", rsp, {2'b10, 32'hDEADBEEF});
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (data_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL stall_no_extra_rvalid got %b exp 0", data_rvalid_o);
        end
    endtask

    task automatic test_error;
        cyc(1'b1, 1'b0, 4'b1111, 32'h1000, 32'h0, 1'b1, 1'b0);
        checks++;
        if (data_gnt_o !== 1'b1) begin
            errors++; $display("FAIL err_first_gnt got %b exp 1", data_gnt_o);
        end
        cyc(1'b1, 1'b0, 4'b1111, 32'h1008, 32'h0, 1'b0, 1'b1);
        checks++;
        if ({data_gnt_o, ahbl_htrans, data_rvalid_o} !== 4'b0000) begin
            errors++; $display("FAIL err_cycle1 got gnt/htrans/rv=%b exp 0000", {data_gnt_o, ahbl_htrans, data_rvalid_o});
        end
        cyc(1'b1, 1'b0, 4'b1111, 32'h1008, 32'h0, 1'b1, 1'b1);
        checks++;
        if ({data_gnt_o, ahbl_htrans, data_rvalid_o, data_err_o} !== 5'b00011) begin
            errors++; $display("FAIL err_cycle2 got gnt/htrans/rv/err=%b exp 00011",
                               {data_gnt_o, ahbl_htrans, data_rvalid_o, data_err_o});
        end
        cyc(1'b1, 1'b0, 4'b1111, 32'h1008, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, ahbl_htrans, data_rvalid_o} !== 4'b1100) begin
            errors++; $display("FAIL err_requeue got gnt/htrans/rv=%b exp 1100", {data_gnt_o, ahbl_htrans, data_rvalid_o});
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_rvalid_o, data_err_o} !== 2'b10) begin
            errors++; $display("FAIL err_requeue_rsp got rv/err=%b%b exp 10", data_rvalid_o, data_err_o);
        end
    endtask

    task automatic test_illegal_be;
        cyc(1'b1, 1'b1, 4'b0101, 32'h1010, 32'hFFFFFFFF, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, ahbl_htrans, data_rvalid_o} !== 4'b1000) begin
            errors++; $display("FAIL illegal_gnt got gnt/htrans/rv=%b exp 1000", {data_gnt_o, ahbl_htrans, data_rvalid_o});
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({rsp, ahbl_htrans} !== {2'b11, 32'h0, 2'b00}) begin
            errors++; $display("FAIL illegal_rsp got rsp=%h htrans=%b exp rsp=%h", rsp, ahbl_htrans, {2'b11, 32'h0});
        end
        // Illegal request behind an outstanding read must wait for the data phase to drain.
        cyc(1'b1, 1'b0, 4'b1111, 32'h1000, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 4'b0110, 32'h1000, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, ahbl_htrans, rsp} !== {3'b000, 2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL illegal_wait got gnt=%b htrans=%b rsp=%h", data_gnt_o, ahbl_htrans, rsp);
        end
        cyc(1'b1, 1'b0, 4'b0110, 32'h1000, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_gnt_o, data_rvalid_o} !== 2'b10) begin
            errors++; $display("FAIL illegal_late_gnt got gnt/rv=%b%b exp 10", data_gnt_o, data_rvalid_o);
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if ({data_rvalid_o, data_err_o} !== 2'b11) begin
            errors++; $display("FAIL illegal_late_rsp got rv/err=%b%b exp 11", data_rvalid_o, data_err_o);
        end
    endtask

    task automatic test_be_decode;
        logic [3:0]  be_tab   [4] = '{4'b0011, 4'b1100, 4'b0010, 4'b1000};
        logic [31:0] addr_tab [4] = '{32'h1000, 32'h1002, 32'h1001, 32'h1003};
        logic [2:0]  size_tab [4] = '{3'd1, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, be_tab[i], 32'h1000, 32'h0, 1'b1, 1'b0);
            checks++;
            if (aph !== {1'b1, 2'b10, addr_tab[i], size_tab[i], 1'b0}) begin
                errors++; $display("FAIL be_decode_%0d got %h exp %h", i, aph,
                                   {1'b1, 2'b10, addr_tab[i], size_tab[i], 1'b0});
            end
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid;
        cyc(1'b1, 1'b1, 4'b1111, 32'h1000, 32'h55, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 4'b1111, 32'h1004, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({data_gnt_o, ahbl_htrans, rsp, ahbl_hwdata} !== {3'b000, 34'h0, 32'h0}) begin
            errors++; $display("FAIL mid_reset got gnt/htrans=%b rsp=%h hwdata=%h", {data_gnt_o, ahbl_htrans}, rsp, ahbl_hwdata);
        end
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (data_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset_no_rvalid got %b exp 0", data_rvalid_o);
        end
    endtask

    initial begin
        test_reset;
        test_write_word;
        test_byte_write;
        test_back_to_back;
        test_stall;
        test_error;
        test_illegal_be;
        test_be_decode;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
